// File: rtl/matrix_result_reader.sv
// rtl/matrix_result_reader.sv - walks the N x N result matrix row-major and shows each element on the LEDs
// Optional build macro: RESULT_LED_SAT_EN (saturate elements above 255 to 8'hFF instead of truncating).
module matrix_result_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int N          = 10,
    parameter int ACC_WIDTH  = 20,
    parameter int DWELL      = 50_000_000,
    parameter int ADDR_W     = 7
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 done,
    output logic                 rd_en,
    output logic [ADDR_W-1:0]    rd_addr,
    input  logic [ACC_WIDTH-1:0] rd_data,
    output logic [7:0]           LED,
    output logic                 busy,
    output logic                 fin
);

    localparam int                CNT_W     = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DWELL - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(N * N - 1);

    if (ACC_WIDTH < 2 * DATA_WIDTH + 1 || ACC_WIDTH < 8) begin : g_bad_acc_width
        $error("ACC_WIDTH too narrow for the multiplier result");
    end
    if ((1 << ADDR_W) < N * N) begin : g_bad_addr_width
        $error("ADDR_W cannot address N*N elements");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_SHOW,
        S_FIN
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic               r_done_q;
    logic [CNT_W-1:0]   r_cnt;
    logic [ADDR_W-1:0]  r_addr;
    logic [7:0]         r_led;
    logic               w_start;
    logic               w_dwell_end;
    logic               w_last_elem;
    logic [7:0]         w_disp;

    assign w_start     = done & ~r_done_q;
    assign w_dwell_end = (r_cnt == CNT_LAST);
    assign w_last_elem = (r_addr == ADDR_LAST);

`ifdef RESULT_LED_SAT_EN
    assign w_disp = (rd_data > ACC_WIDTH'(255)) ? 8'hFF : rd_data[7:0];
`else
    logic w_unused_hi;
    assign w_disp      = rd_data[7:0];
    assign w_unused_hi = ^rd_data[ACC_WIDTH-1:8];
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_start) w_next = S_REQ;
            S_REQ:  w_next = S_WAIT;
            S_WAIT: w_next = S_SHOW;
            S_SHOW: begin
                if (w_dwell_end) begin
                    w_next = w_last_elem ? S_FIN : S_REQ;
                end
            end
            S_FIN:  if (w_start) w_next = S_REQ;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // rd_data is only trustworthy in WAIT, so that is the single cycle the LED latch opens.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_done_q <= 1'b0;
            r_cnt    <= '0;
            r_addr   <= '0;
            r_led    <= 8'h00;
        end else begin
            r_done_q <= done;
            case (r_state)
                S_IDLE, S_FIN: begin
                    if (w_start) begin
                        r_addr <= '0;
                    end
                    r_cnt <= '0;
                end
                S_WAIT: begin
                    r_led <= w_disp;
                    r_cnt <= '0;
                end
                S_SHOW: begin
                    if (w_dwell_end) begin
                        r_cnt <= '0;
                        if (!w_last_elem) begin
                            r_addr <= r_addr + 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_cnt <= r_cnt;
                end
            endcase
        end
    end

    assign rd_en   = (r_state == S_REQ);
    assign busy    = (r_state == S_REQ) || (r_state == S_WAIT) || (r_state == S_SHOW);
    assign fin     = (r_state == S_FIN);
    assign rd_addr = r_addr;
    assign LED     = r_led;

endmodule

// File: tb/tb_matrix_result_reader.sv
// tb/tb_matrix_result_reader.sv - self-checking bench for matrix_result_reader
module tb_matrix_result_reader;

    localparam int N         = 2;
    localparam int DWELL     = 4;
    localparam int ADDR_W    = 2;
    localparam int ACC_WIDTH = 20;
    localparam int NE        = N * N;
    localparam int PERIOD    = DWELL + 2;
    localparam int TOTAL     = NE * PERIOD;
`ifdef RESULT_LED_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 done = 1'b0;
    logic                 rd_en;
    logic [ADDR_W-1:0]    rd_addr;
    logic [ACC_WIDTH-1:0] rd_data = '0;
    logic [7:0]           LED;
    logic                 busy;
    logic                 fin;

    logic [ACC_WIDTH-1:0] mem [NE];
    logic [7:0]           obs [NE];
    logic [7:0]           prev_led;
    logic                 mon_prev_en = 1'b0;
    int                   n_cmp = 0;
    int                   n_fail = 0;

    typedef struct packed {
        logic [NE-1:0][ACC_WIDTH-1:0] c;
        logic [NE-1:0][7:0]           led;
    } vec_t;
    vec_t vecs [3];

    always #5 clk = ~clk;

    matrix_result_reader #(
        .DATA_WIDTH(8), .N(N), .ACC_WIDTH(ACC_WIDTH), .DWELL(DWELL), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk), .rst(rst), .done(done), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data), .LED(LED), .busy(busy), .fin(fin)
    );

    // Result memory: data valid the cycle after rd_en, garbage otherwise.
    always @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_addr];
        else       rd_data <= ACC_WIDTH'($urandom);
    end

    always @(negedge clk) begin
        if (rst) begin
            n_cmp = n_cmp + 1;
            if (rd_addr > ADDR_W'(NE - 1)) begin
                n_fail = n_fail + 1;
                $display("FAIL proto_addr: rd_addr=%0d exceeds %0d", rd_addr, NE - 1);
            end
            n_cmp = n_cmp + 1;
            if (rd_en && (mon_prev_en || !busy || fin)) begin
                n_fail = n_fail + 1;
                $display("FAIL proto_rd_en: rd_en=1 with prev_en=%0b busy=%0b fin=%0b", mon_prev_en, busy, fin);
            end
        end
        mon_prev_en <= rd_en;
    end

    function automatic logic [7:0] disp(input logic [ACC_WIDTH-1:0] v);
        if (SAT && v > 255) return 8'hFF;
        return v[7:0];
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp = n_cmp + 1;
        if (act != exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called at a sample point with done low at the previous edge; checks the whole
    // trace against the per-cycle schedule implied by element index and phase.
    task automatic run_readout(input bit jitter);
        int e, p;
        logic       x_en, x_busy, x_fin;
        logic [1:0] x_addr;
        logic [7:0] x_led;
        done = 1'b1;
        for (int j = 0; j < TOTAL + 4; j++) begin
            tick();
            if (j < TOTAL) begin
                e      = j / PERIOD;
                p      = j % PERIOD;
                x_en   = (p == 0);
                x_addr = 2'(e);
                x_busy = 1'b1;
                x_fin  = 1'b0;
                if (p >= 2)     x_led = disp(mem[e]);
                else if (e > 0) x_led = disp(mem[e - 1]);
                else            x_led = prev_led;
                if (p == 2) obs[e] = LED;
            end else begin
                x_en   = 1'b0;
                x_addr = 2'(NE - 1);
                x_busy = 1'b0;
                x_fin  = 1'b1;
                x_led  = disp(mem[NE - 1]);
            end
            chk($sformatf("rd_en j=%0d", j), int'(rd_en), int'(x_en));
            chk($sformatf("rd_addr j=%0d", j), int'(rd_addr), int'(x_addr));
            chk($sformatf("busy j=%0d", j), int'(busy), int'(x_busy));
            chk($sformatf("fin j=%0d", j), int'(fin), int'(x_fin));
            chk($sformatf("LED j=%0d", j), int'(LED), int'(x_led));
            if (jitter) done = (j < TOTAL - 4) ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        prev_led = disp(mem[NE - 1]);
    endtask

    initial begin
        vecs[0].c   = {20'd200, 20'd12, 20'd7, 20'd3};
        vecs[0].led = {8'hC8, 8'h0C, 8'h07, 8'h03};
        vecs[1].c   = {20'd256, 20'd0, 20'd300, 20'd255};
        vecs[1].led = {(SAT ? 8'hFF : 8'h00), 8'h00, (SAT ? 8'hFF : 8'h2C), 8'hFF};
        vecs[2].c   = {20'h00181, 20'd1, 20'd128, 20'hFFFFF};
        vecs[2].led = {(SAT ? 8'hFF : 8'h81), 8'h01, 8'h80, 8'hFF};

        repeat (2) tick();
        chk("reset rd_en", int'(rd_en), 0);
        chk("reset busy", int'(busy), 0);
        chk("reset fin", int'(fin), 0);
        chk("reset LED", int'(LED), 0);
        chk("reset rd_addr", int'(rd_addr), 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) tick();
        prev_led = 8'h00;

        for (int v = 0; v < 3; v++) begin
            for (int i = 0; i < NE; i++) mem[i] = vecs[v].c[i];
            run_readout(1'b0);
            for (int i = 0; i < NE; i++)
                chk($sformatf("table%0d elem%0d LED", v, i), int'(obs[i]), int'(vecs[v].led[i]));
            for (int k = 0; k < 10; k++) begin
                tick();
                chk($sformatf("table%0d held fin", v), int'(fin), 1);
                chk($sformatf("table%0d held rd_en", v), int'(rd_en), 0);
                chk($sformatf("table%0d held LED", v), int'(LED), int'(vecs[v].led[NE - 1]));
            end
            done = 1'b0;
            tick();
        end

        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < NE; i++)
                mem[i] = (r % 2 == 0) ? ACC_WIDTH'($urandom_range(0, 511)) : ACC_WIDTH'($urandom);
            run_readout(1'b1);
            done = 1'b0;
            tick();
        end

        // Reset in the middle of SHOW aborts immediately and stays idle afterwards.
        mem[0] = 20'd3; mem[1] = 20'd7; mem[2] = 20'd12; mem[3] = 20'd200;
        done = 1'b1;
        repeat (4) tick();
        chk("pre-reset busy", int'(busy), 1);
        rst = 1'b0;
        #1;
        chk("midreset LED", int'(LED), 0);
        chk("midreset rd_en", int'(rd_en), 0);
        chk("midreset busy", int'(busy), 0);
        chk("midreset fin", int'(fin), 0);
        chk("midreset rd_addr", int'(rd_addr), 0);
        done = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("post-reset busy", int'(busy), 0);
            chk("post-reset fin", int'(fin), 0);
            chk("post-reset rd_en", int'(rd_en), 0);
        end
        prev_led = 8'h00;
        run_readout(1'b0);
        done = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
